instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Producer side of the decoder's instr port: issues PC-addressed reads to instruction memory and buffers the returned words.
//  Presents {instr, instr_pc} to the decoder stage with a valid/ready handshake.
//  Accepts a redirect from execute (branch/jump) that discards all wrong-path fetches.
//  Sits between imem and decoder.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  FIFO_DEPTH 2              output buffer entries; power of two, >=2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_req_addr   out  32  byte address of request, word aligned
//  imem_rsp_valid  in   1   read data valid; always accepted, at most one outstanding
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   one-cycle pulse, new fetch target
//  redirect_pc     in   32  target; bits [1:0] ignored (forced 0)
//  instr_valid     out  1   instr/instr_pc valid to decoder
//  instr_ready     in   1   decoder consumes this cycle
//  instr           out  32  instruction word
//  instr_pc        out  32  address of instr
// BEHAVIOUR
//  Reset (async assert, sync deassert use): pc=RESET_PC, state=REQ, FIFO empty,
//   imem_req_valid=0 during reset, instr_valid=0, instr=0, instr_pc=0.
//  FSM states: REQ, WAIT, DROP, HOLD.
//   REQ : req_valid=1, req_addr=pc; on req_ready -> WAIT, store pc in issue_pc.
//         Hold addr stable while !req_ready.
//   WAIT: on rsp_valid push {rsp_data, issue_pc}, pc+=4; -> REQ if FIFO has space
//         after push, else HOLD.
//   HOLD: req_valid=0; -> REQ when FIFO not full.
//   DROP: outstanding wrong-path response; on rsp_valid discard -> REQ.
//  Issue only when a free slot is guaranteed: count + outstanding < FIFO_DEPTH.
//  Steady-state latency: request accepted cycle N, response N+k, instr_valid at N+k+1 (registered FIFO output).
//  Output handshake: transfer when instr_valid && instr_ready.
//   - instr/instr_pc held stable while valid && !ready.
//   - FIFO head is popped on transfer.
//   - Simultaneous push and pop on a full FIFO is legal.
//  Redirect (highest priority, same-cycle):
//   - FIFO flushed.
//   - instr_valid=0 next cycle.
//   - pc = {redirect_pc[31:2], 2'b00}.
//   - State transitions:
//     - WAIT -> DROP, unless rsp_valid arrives in the same cycle; that response is discarded and state -> REQ.
//     - REQ with req_ready same cycle -> DROP.
//     - REQ with no handshake -> REQ; addr changes next cycle.
//     - HOLD -> REQ.
//     - DROP -> DROP.
//  PC wraps 32'hFFFF_FFFC -> 0 silently.
//  rsp_valid in REQ/HOLD (no outstanding): ignored.
//  Reset mid-transaction: outstanding response after reset is not expected; memory is reset together.
// STRUCTURE
//  Shared package/header: XLEN=32, INSTR_NOP=32'h0000_0013, fetch-state encodings.
//  Sub-module fetch_fifo: sync FIFO, width 64 ({pc,instr}), depth FIFO_DEPTH.
//   - push/pop/flush/full/empty/count.
//   - Flush has priority over push.
//  Top holds pc, issue_pc, FSM, redirect logic.
// TESTING
//  Reset with RESET_PC=0, imem ready/1-cycle rsp, instr_ready=1:
//   - addrs 0,4,8.
//   - instr 32'h002080b3 at pc 0, then 32'hfff38293 at pc 4, one word per 2 cycles.
//  instr_ready=0 for 10 cycles:
//   - FIFO fills to 2, req_valid drops (HOLD).
//   - instr stays 32'h002080b3/pc 0.
//   - On release, pcs 0,4,8 delivered in order, no loss or duplication.
//  imem_req_ready low 3 cycles in REQ -> req_addr stable at 32'h8, no state change.
//  Redirect to 32'h0000_0103 while WAIT:
//   - next fetch addr 32'h100.
//   - the pending response (32'hffdff1ef) dropped, never appears on instr.
//   - FIFO empty.
//  Redirect in same cycle as rsp_valid -> response discarded, instr_pc of next output = redirect target.
//  Assert rst_n low mid-WAIT with FIFO holding 1 entry:
//   - instr_valid=0, req_valid=0 immediately (async).
//   - Fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module : instr_fetch_pkg
// Shared widths, constants and fetch FSM encoding for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Synchronous FIFO holding {pc, instr} pairs; flush overrides push.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int              AW          = $clog2(DEPTH);
    localparam logic [AW:0]     C_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0]     C_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   C_PTR_ONE   = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != C_DEPTH) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Issues PC-addressed imem reads, buffers returned words and hands them to
// the decoder; execute redirects squash all wrong-path fetches.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   C_LAST  = CW'(FIFO_DEPTH - 1);
    localparam logic [31:0]     C_RST_PC = {RESET_PC[31:2], 2'b00};

    fetch_state_e       r_state;
    fetch_state_e       w_state_nx;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_issue_pc;
    logic               r_run;
    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_space_after_push;
    logic [CW-1:0]      w_count;
    logic [63:0]        w_rdata;
    logic               w_unused_redirect_lsbs;

    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    // r_run keeps the request line low for the whole reset window, including
    // the first cycle after release.
    assign imem_req_valid = r_run && (r_state == ST_REQ) && !w_full;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_pop          = instr_valid && instr_ready;
    assign w_space_after_push = w_pop || (w_count < C_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_push     = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_state_nx = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_state_nx = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    w_push     = 1'b1;
                    w_state_nx = w_space_after_push ? ST_REQ : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || !w_full) begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_DROP: begin
                // The wrong-path response retires the outstanding read even if
                // another redirect lands in the same cycle.
                if (imem_rsp_valid) begin
                    w_state_nx = ST_REQ;
                end
            end
            default: w_state_nx = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_REQ;
            r_pc       <= C_RST_PC;
            r_issue_pc <= C_RST_PC;
            r_run      <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_run   <= 1'b1;
            if (w_req_fire) begin
                r_issue_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata ({r_issue_pc, imem_rsp_data}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign instr_valid = !w_empty;
    assign instr_pc    = w_rdata[63:32];
    assign instr       = w_rdata[31:0];

endmodule

`default_nettype wire
